// File: rtl/pipe_pkg.sv
// Shared types for the handshaked pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int DEFAULT_CTRL_W = 16;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot: a valid bit plus a payload register. Clear wins over load;
// clearing keeps the payload so the stage output holds its last value.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] payload_i,
  output logic         valid_o,
  output logic [W-1:0] payload_o
);

  logic         valid_q;
  logic [W-1:0] payload_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (clear_i) begin
      valid_q   <= 1'b0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      payload_q <= payload_i;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/elastic_pipe_stage.sv
// Handshaked pipeline stage register with optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int DATA_W = 160,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  localparam int PW = CTRL_W + DATA_W;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and a held entry stays stable until it fires.
  logic in_fire, out_fire;

  pipe_state_t      state_q, state_d;
  logic             main_load, main_clear, main_from_skid;
  logic             skid_load, skid_clear;
  logic             main_valid, skid_valid;
  logic [PW-1:0]    main_payload, skid_payload, main_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load_i    (skid_load),
        .clear_i   (skid_clear),
        .payload_i ({in_ctrl, in_data}),
        .valid_o   (skid_valid),
        .payload_o (skid_payload)
      );
      // Skid slot valid is exactly state FULL, so in_ready comes straight from a flop.
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign skid_valid   = 1'b0;
      assign skid_payload = '0;
      assign in_ready     = ~main_valid | out_ready;
    end
  endgenerate

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID != 0) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_payload : {in_ctrl, in_data};

  pipe_slot #(.W(PW)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load_i    (main_load),
    .clear_i   (main_clear),
    .payload_i (main_d),
    .valid_o   (main_valid),
    .payload_o (main_payload)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Invalid stage must look like a bubble downstream, so control is masked.
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_payload[PW-1 -: CTRL_W] : '0;
  assign out_data  = main_payload[DATA_W-1:0];
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Bench for elastic_pipe_stage: skid instance (CNT_W=4) and no-skid instance,
// each checked against a queue-based model of the stage.
module tb_elastic_pipe_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // Instance A: SKID=1, CNT_W=4
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_flush = 0;
  logic [15:0] a_in_ctrl = 0, a_out_ctrl;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [3:0]  a_stall_cnt;
  logic [1:0]  a_dbg;

  // Instance B: SKID=0
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_flush = 0;
  logic [15:0] b_in_ctrl = 0, b_out_ctrl;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [15:0] b_stall_cnt;
  logic [1:0]  b_dbg;

  elastic_pipe_stage #(.CTRL_W(16), .DATA_W(32), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .flush(a_flush), .stall_cnt(a_stall_cnt), .dbg_state(a_dbg)
  );

  elastic_pipe_stage #(.CTRL_W(16), .DATA_W(32), .SKID(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .flush(b_flush), .stall_cnt(b_stall_cnt), .dbg_state(b_dbg)
  );

  // Reference model: entries held, in acceptance order
  logic [47:0] a_q[$];
  int          a_stall;
  logic [31:0] a_last;
  logic        a_pre_ready, a_exp_ready;

  logic [47:0] b_q[$];
  int          b_stall;
  logic        b_pre_ready, b_exp_ready, b_pre_valid, b_exp_valid;
  logic [31:0] b_pre_data;
  logic        b_acc;
  logic [31:0] exp_q[$];

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    a_in_valid = 0; a_flush = 0; a_out_ready = 1;
    b_in_valid = 0; b_flush = 0; b_out_ready = 1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a_q.delete(); a_stall = 0; a_last = '0;
    b_q.delete(); b_stall = 0;
  endtask

  task automatic a_step(input logic v, input logic [15:0] c, input logic [31:0] d,
                        input logic ordy, input logic fl);
    int   sz;
    logic inf, outf;
    a_in_valid = v; a_in_ctrl = c; a_in_data = d; a_out_ready = ordy; a_flush = fl;
    @(negedge clk);
    a_pre_ready = a_in_ready;
    sz = a_q.size();
    a_exp_ready = (sz < 2);
    inf  = v && (sz < 2);
    outf = (sz > 0) && ordy;
    @(posedge clk);
    if (rst) begin
      a_q.delete(); a_stall = 0; a_last = '0;
    end else begin
      if (sz > 0 && !ordy && a_stall < 15) a_stall++;
      if (fl) a_q.delete();
      else begin
        if (outf) void'(a_q.pop_front());
        if (inf) a_q.push_back({c, d});
      end
      if (a_q.size() > 0) a_last = a_q[0][31:0];
    end
    #1;
  endtask

  task automatic b_step(input logic v, input logic [31:0] d, input logic ordy);
    int   sz;
    logic outf;
    b_in_valid = v; b_in_ctrl = d[15:0]; b_in_data = d; b_out_ready = ordy; b_flush = 0;
    @(negedge clk);
    b_pre_ready = b_in_ready;
    b_pre_valid = b_out_valid;
    b_pre_data  = b_out_data;
    sz = b_q.size();
    b_exp_ready = (sz == 0) || ordy;
    b_exp_valid = (sz > 0);
    b_acc = v && b_exp_ready;
    outf  = (sz > 0) && ordy;
    @(posedge clk);
    if (sz > 0 && !ordy) b_stall++;
    if (outf) void'(b_q.pop_front());
    if (b_acc) b_q.push_back({d[15:0], d});
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", a_out_valid); end
    n_checks++; if (a_out_ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_out_ctrl: got %0h expected 0", a_out_ctrl); end
    n_checks++; if (a_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", a_out_data); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", a_in_ready); end
    n_checks++; if (a_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", a_stall_cnt); end
    n_checks++; if (a_dbg !== EMPTY) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", a_dbg, EMPTY); end
    n_checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_noskid: got ready %0b valid %0b expected ready 1 valid 0", b_in_ready, b_out_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      a_step(1'b1, 16'($urandom), 32'(i), 1'b1, 1'b0);
      n_checks++; if (a_pre_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, a_pre_ready); end
      n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(i)) begin
        n_fail++; $display("FAIL stream_out[%0d]: got valid %0b data %0h expected valid 1 data %0h", i, a_out_valid, a_out_data, i);
      end
      n_checks++; if (a_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL stream_stall[%0d]: got %0d expected 0", i, a_stall_cnt); end
    end
    a_step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0 || a_out_data !== 32'd8) begin
      n_fail++; $display("FAIL stream_drain: got valid %0b ctrl %0h data %0h expected valid 0 ctrl 0 data 8", a_out_valid, a_out_ctrl, a_out_data);
    end
  endtask

  task automatic test_stall_fill_drain();
    logic [31:0] dat[5];
    logic [15:0] ctl[5];
    logic        vld[5];
    logic        rdy_post[5];
    int          stl[5];
    dat = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hB};
    ctl = '{16'h1, 16'h1, 16'h1, 16'h2, 16'h0};
    vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rdy_post = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    stl = '{0, 1, 2, 2, 2};
    do_reset();
    a_step(1'b1, 16'h1, 32'hA, 1'b0, 1'b0);
    a_step(1'b1, 16'h2, 32'hB, 1'b0, 1'b0);
    a_step(1'b1, 16'h3, 32'hC, 1'b0, 1'b0);
    n_checks++; if (a_pre_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %0b expected 0", a_pre_ready); end
    a_step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    a_step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    // Replay the same sequence, checking every cycle against the directed table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) a_step(1'b1, 16'(i + 1), 32'hA + 32'(i), 1'b0, 1'b0);
      else       a_step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (a_out_valid !== vld[i] || a_out_ctrl !== ctl[i]) begin
        n_fail++; $display("FAIL fill_drain_head[%0d]: got valid %0b ctrl %0h expected valid %0b ctrl %0h", i, a_out_valid, a_out_ctrl, vld[i], ctl[i]);
      end
      n_checks++; if (a_out_data !== dat[i]) begin n_fail++; $display("FAIL fill_drain_data[%0d]: got %0h expected %0h", i, a_out_data, dat[i]); end
      n_checks++; if (a_in_ready !== rdy_post[i]) begin n_fail++; $display("FAIL fill_drain_ready[%0d]: got %0b expected %0b", i, a_in_ready, rdy_post[i]); end
      n_checks++; if (a_stall_cnt !== 4'(stl[i])) begin n_fail++; $display("FAIL fill_drain_stall[%0d]: got %0d expected %0d", i, a_stall_cnt, stl[i]); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    a_step(1'b1, 16'h11, 32'h11, 1'b0, 1'b0);
    a_step(1'b1, 16'h22, 32'h22, 1'b0, 1'b0);
    a_step(1'b1, 16'hFFFF, 32'h33, 1'b0, 1'b1);
    n_checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0 || a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: got valid %0b ctrl %0h ready %0b expected valid 0 ctrl 0 ready 1", a_out_valid, a_out_ctrl, a_in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      a_step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0) begin
        n_fail++; $display("FAIL flush_after[%0d]: got valid %0b ctrl %0h expected valid 0 ctrl 0", i, a_out_valid, a_out_ctrl);
      end
    end
    // Flush in BUSY while the offered entry is taken: it must be dropped
    a_step(1'b1, 16'h4, 32'h44, 1'b0, 1'b0);
    a_step(1'b1, 16'hFFFF, 32'h55, 1'b1, 1'b1);
    n_checks++; if (a_pre_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0) begin
      n_fail++; $display("FAIL flush_busy: got ready %0b valid %0b ctrl %0h expected ready 1 valid 0 ctrl 0", a_pre_ready, a_out_valid, a_out_ctrl);
    end
    a_step(1'b0, 16'h0, 32'h0, 1'b1, 1'b0);
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_busy_after: got valid %0b expected 0", a_out_valid); end
  endtask

  task automatic test_stall_saturation();
    do_reset();
    a_step(1'b1, 16'h7, 32'h77, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      a_step(1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
      n_checks++; if (a_stall_cnt !== 4'((i < 15) ? i : 15)) begin
        n_fail++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, a_stall_cnt, (i < 15) ? i : 15);
      end
    end
    a_step(1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
    n_checks++; if (a_stall_cnt !== 4'd15 || a_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL sat_after_flush: got cnt %0d valid %0b expected cnt 15 valid 0", a_stall_cnt, a_out_valid);
    end
    do_reset();
    n_checks++; if (a_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_after_rst: got %0d expected 0", a_stall_cnt); end
  endtask

  task automatic test_rst_full_flush();
    do_reset();
    a_step(1'b1, 16'h1, 32'h81, 1'b0, 1'b0);
    a_step(1'b1, 16'h2, 32'h82, 1'b0, 1'b0);
    rst = 1'b1;
    a_step(1'b1, 16'hFFFF, 32'h99, 1'b0, 1'b1);
    rst = 1'b0;
    n_checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 16'h0 || a_out_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_full_out: got valid %0b ctrl %0h data %0h expected all 0", a_out_valid, a_out_ctrl, a_out_data);
    end
    n_checks++; if (a_in_ready !== 1'b1 || a_stall_cnt !== 4'd0 || a_dbg !== EMPTY) begin
      n_fail++; $display("FAIL rst_full_state: got ready %0b cnt %0d state %0d expected ready 1 cnt 0 state 0", a_in_ready, a_stall_cnt, a_dbg);
    end
    a_step(1'b1, 16'h5, 32'h55, 1'b1, 1'b0);
    n_checks++; if (a_out_valid !== 1'b1 || a_out_ctrl !== 16'h5 || a_out_data !== 32'h55) begin
      n_fail++; $display("FAIL rst_first_entry: got valid %0b ctrl %0h data %0h expected 1 5 55", a_out_valid, a_out_ctrl, a_out_data);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp_ctrl;
    int          errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      a_step(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
      exp_ctrl = (a_q.size() > 0) ? a_q[0][47:32] : 16'h0;
      n_checks++;
      if (a_out_valid !== (a_q.size() > 0) || a_out_ctrl !== exp_ctrl || a_out_data !== a_last ||
          a_stall_cnt !== 4'(a_stall) || a_pre_ready !== a_exp_ready) begin
        n_fail++;
        if (errs < 10) $display("FAIL random[%0d]: got v%0b c%0h d%0h s%0d r%0b expected v%0b c%0h d%0h s%0d r%0b",
          i, a_out_valid, a_out_ctrl, a_out_data, a_stall_cnt, a_pre_ready,
          (a_q.size() > 0), exp_ctrl, a_last, a_stall, a_exp_ready);
        errs++;
      end
    end
  endtask

  task automatic test_no_skid();
    int seq;
    int rcv;
    do_reset();
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back(32'(i));
    seq = 1;
    rcv = 0;
    for (int cyc = 0; cyc < 80 && exp_q.size() > 0; cyc++) begin
      b_step(seq <= 16, 32'(seq), (cyc % 2) == 0);
      n_checks++; if (b_pre_ready !== b_exp_ready || b_pre_valid !== b_exp_valid) begin
        n_fail++; $display("FAIL noskid_ready[%0d]: got ready %0b valid %0b expected ready %0b valid %0b", cyc, b_pre_ready, b_pre_valid, b_exp_ready, b_exp_valid);
      end
      if (b_exp_valid && (cyc % 2) == 0) begin
        rcv++;
        n_checks++; if (b_pre_data !== exp_q[0]) begin n_fail++; $display("FAIL noskid_order[%0d]: got %0h expected %0h", cyc, b_pre_data, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      if (b_acc) seq++;
    end
    n_checks++; if (exp_q.size() != 0 || rcv != 16) begin
      n_fail++; $display("FAIL noskid_count: got %0d received expected 16", rcv);
    end
    n_checks++; if (b_stall_cnt !== 16'(b_stall)) begin n_fail++; $display("FAIL noskid_stall: got %0d expected %0d", b_stall_cnt, b_stall); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill_drain();
    test_flush();
    test_stall_saturation();
    test_rst_full_flush();
    test_random();
    test_no_skid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_stage.md
# elastic_pipe_stage

Parametrised, handshaked pipeline stage register, the successor to the fixed-field stage registers between decode, execute, memory and writeback. It carries an opaque control field and an opaque data field with valid/ready flow control instead of a global enable. It has an optional two-entry skid buffer that registers the upstream ready, and a flush that turns the stage into a bubble. It sits between any two pipeline stages of the core; stall/flush from the hazard unit map onto `out_ready`/`flush`.

## Interface

Parameters:
- `CTRL_W`, default 16: control field width; zeroed whenever the stage holds no valid entry.
- `DATA_W`, default 160: data field width (operands, PC, immediates, register indices).
- `SKID`, default 1: 1 selects a 2-entry buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, default 16: stall counter width.

Ports (reset rst, synchronous, active-high; clock clk):
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: upstream entry present.
- `in_ready`, out, 1: stage can accept this cycle.
- `in_ctrl`, in, `CTRL_W`: upstream control field.
- `in_data`, in, `DATA_W`: upstream data field.
- `out_valid`, out, 1: stage holds a valid entry.
- `out_ready`, in, 1: downstream accepts (0 = stall).
- `out_ctrl`, out, `CTRL_W`: control field of the head entry; all zeros when `out_valid`=0.
- `out_data`, out, `DATA_W`: data field of the head entry; holds its last value when invalid.
- `flush`, in, 1: discard all held entries and any entry offered this cycle.
- `stall_cnt`, out, `CNT_W`: saturating count of stalled cycles.

## Operation

- Definitions: `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- States:
  - EMPTY: no entry.
  - BUSY: main slot valid.
  - FULL: main and skid slots both valid. FULL exists only when `SKID`=1.
- `in_ready`:
  - With `SKID`=1: `in_ready` = (state != FULL). It is a pure register output.
  - With `SKID`=0: `in_ready` = !`out_valid` | `out_ready`.
- Transitions when `flush`=0:
  - EMPTY: if `in_fire`, load main and go to BUSY.
  - BUSY, `in_fire` & `out_fire`: load main with the input and stay BUSY.
  - BUSY, `in_fire` & !`out_fire`: with `SKID`=1, load skid and go to FULL. With `SKID`=0 this case cannot occur.
  - BUSY, !`in_fire` & `out_fire`: go to EMPTY.
  - BUSY, otherwise: hold.
  - FULL: if `out_fire`, move skid into main and go to BUSY. No `in_fire` is possible in FULL.
- Flush:
  - `flush`=1 forces EMPTY next cycle, whatever the current state or `in_fire`.
  - The entry offered in that cycle is dropped. The upstream sees it accepted if `in_ready`=1 and must not re-send it.
  - `out_fire` in the flush cycle still counts as a completed transfer.
- Ordering: entries leave strictly in acceptance order; the skid entry is never presented before the main entry.
- Control zeroing: `out_ctrl` is all zeros whenever `out_valid`=0, so a flushed or empty stage emits a bubble with RegWrite/MemWrite/Branch/Jump all clear.
- Stall counter:
  - `stall_cnt` increments in any cycle with `out_valid` & !`out_ready`.
  - It saturates at 2^`CNT_W`−1.
  - It is cleared only by `rst`; `flush` does not clear it.
- Reset: `rst` takes priority over `flush` and over every handshake.

## Timing

- Latency: an entry accepted at edge N is visible on `out_*` with `out_valid`=1 after edge N (next cycle).
- Throughput: one entry per cycle while `out_ready`=1.
- Backpressure:
  - With `SKID`=1, `in_ready` falls one cycle after the first stalled cycle that also accepted an entry. At most 2 entries are held.
  - With `SKID`=0, `in_ready` follows `out_ready` in the same cycle.
- Flush: `out_valid`=0 in the cycle after `flush` is sampled. With `SKID`=1, `in_ready`=1 in that cycle as well.
- Values after reset:
  - `out_valid`=0.
  - `out_ctrl`=0.
  - `out_data`=0.
  - `in_ready`=1 in both modes.
  - `stall_cnt`=0.
  - State = EMPTY.
  - Skid slot contents are zero.

## Structure

- Shared package `pipe_pkg`: state enum `pipe_state_t` {EMPTY, BUSY, FULL} and a default `CTRL_W` constant.
- One sub-module, `pipe_slot`: a valid bit plus a `CTRL_W`+`DATA_W` payload register with `load`, `clear` and synchronous reset.
- The main slot always exists; the skid slot is created in a generate block only when `SKID`=1.
- The FSM and the stall counter live in the top level.

## Test plan

- Streaming, `SKID`=1: `out_ready`=1, `in_valid`=1 for 8 cycles with `in_data`=1..8. Required: `out_data`=1..8 on 8 consecutive cycles, each one cycle after acceptance; `in_ready` stays 1; `stall_cnt`=0.
- Stall fill/drain: `in_data` 0xA then 0xB accepted while `out_ready`=0. Required: `in_ready`=0 after 2 accepts; `out_data`=0xA held; `stall_cnt` increments each stalled cycle. After `out_ready`=1, 0xA then 0xB appear in order, then `out_valid`=0.
- Flush in FULL with a concurrent offer, `in_ctrl`=0xFFFF: assert `flush` for one cycle. Required: next cycle `out_valid`=0, `out_ctrl`=0x0000, `in_ready`=1; no held or offered entry ever appears at the output.
- Stall counter saturation with `CNT_W`=4: stall for 20 cycles. Required: `stall_cnt`=15 and held. A following `flush` leaves it at 15; `rst` returns it to 0.
- `SKID`=0 mode: toggle `out_ready` every cycle. Required: `in_ready` equals `out_ready` | !`out_valid` in the same cycle; no entry lost or duplicated over 16 entries.
- `rst` asserted while FULL with `flush` also high. Required: next cycle all outputs at their reset values, and the first new entry is accepted normally.
